// File: rtl/voice_alloc.sv
// voice_alloc: shares a pool of oscillator voices among incoming note events, stealing the voice closest to release when full.
// Optional feature macro VOICE_STEAL_CNT_EN adds an 8-bit saturating steal_count output.
module voice_alloc #(
    parameter int unsigned VOICES = 4,
    parameter int unsigned CYC_W  = 16,
    parameter int unsigned HOLD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    note_valid,
    input  logic [CYC_W-1:0]        note_cyc,
    input  logic [HOLD_W-1:0]       note_hold,
    output logic                    note_ready,
    output logic [VOICES*CYC_W-1:0] voice_cyc,
    output logic [VOICES-1:0]       voice_active,
    output logic [VOICES-1:0]       voice_attack,
    output logic                    all_busy
`ifdef VOICE_STEAL_CNT_EN
    ,
    output logic [7:0]              steal_count
`endif
);
    localparam int unsigned IDX_W = $clog2(VOICES);

    typedef enum logic {IDLE, ASSIGN} state_t;

    state_t            state;
    logic [CYC_W-1:0]  lat_cyc;
    logic [HOLD_W-1:0] lat_hold;
    logic [HOLD_W-1:0] remaining [VOICES];

    logic              free_found_c;
    logic [IDX_W-1:0]  free_idx_c;
    logic [IDX_W-1:0]  steal_idx_c;
    logic [IDX_W-1:0]  sel_idx_c;
    logic [HOLD_W-1:0] min_rem_c;
    logic              do_assign_c;
    logic              do_steal_c;
    logic [VOICES-1:0] assign_hit_c;
    logic [VOICES-1:0] active_nxt_c;
    logic [HOLD_W-1:0] rem_nxt_c [VOICES];

    // Lowest-index idle voice; scanning downward lets the lowest index win.
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        for (int i = int'(VOICES) - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
        end
    end

    // Steal candidate: smallest remaining hold, strict compare keeps ties at the lower index.
    always_comb begin
        steal_idx_c = '0;
        min_rem_c   = remaining[0];
        for (int i = 1; i < int'(VOICES); i++) begin
            if (remaining[i] < min_rem_c) begin
                steal_idx_c = IDX_W'(i);
                min_rem_c   = remaining[i];
            end
        end
    end

    assign sel_idx_c   = free_found_c ? free_idx_c : steal_idx_c;
    assign do_assign_c = (state == ASSIGN) && (lat_cyc != '0);
    assign do_steal_c  = do_assign_c && !free_found_c;

    // Per-voice next state: an assignment overrides a coincident tick on that voice.
    always_comb begin
        assign_hit_c = '0;
        active_nxt_c = voice_active;
        for (int i = 0; i < int'(VOICES); i++) begin
            rem_nxt_c[i] = remaining[i];
            if (do_assign_c && (sel_idx_c == IDX_W'(i))) begin
                assign_hit_c[i] = 1'b1;
                active_nxt_c[i] = 1'b1;
                rem_nxt_c[i]    = lat_hold;
            end else if (tick && voice_active[i]) begin
                if (remaining[i] != '0) begin
                    rem_nxt_c[i] = remaining[i] - HOLD_W'(1);
                end else begin
                    active_nxt_c[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            note_ready   <= 1'b1;
            lat_cyc      <= '0;
            lat_hold     <= '0;
            voice_cyc    <= '0;
            voice_active <= '0;
            voice_attack <= '0;
            all_busy     <= 1'b0;
            for (int i = 0; i < int'(VOICES); i++) begin
                remaining[i] <= '0;
            end
        end else begin
            voice_active <= active_nxt_c;
            voice_attack <= assign_hit_c;
            all_busy     <= &active_nxt_c;
            for (int i = 0; i < int'(VOICES); i++) begin
                remaining[i] <= rem_nxt_c[i];
                if (assign_hit_c[i]) begin
                    voice_cyc[i*CYC_W +: CYC_W] <= lat_cyc;
                end
            end
            case (state)
                IDLE: begin
                    if (note_valid) begin
                        lat_cyc    <= note_cyc;
                        lat_hold   <= note_hold;
                        state      <= ASSIGN;
                        note_ready <= 1'b0;
                    end
                end
                ASSIGN: begin
                    state      <= IDLE;
                    note_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    note_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef VOICE_STEAL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steal_count <= '0;
        end else if (do_steal_c && (steal_count != 8'hFF)) begin
            steal_count <= steal_count + 8'd1;
        end
    end
`else
    logic unused_steal_c;
    assign unused_steal_c = do_steal_c;
`endif

endmodule
